// File: rtl/avg_pool_channel_sched.sv
// Time-multiplexes one single-channel average-pooling engine across CHANNEL_COUNT
// channels: steps through the masked channels in ascending order and latches each result.
module avg_pool_channel_sched #(
  parameter int unsigned DATAWIDTH     = 32,
  parameter int unsigned CHANNEL_COUNT = 4,
  parameter logic [15:0] TIMEOUT       = 16'd1023,
  localparam int unsigned CH_W         = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [CHANNEL_COUNT-1:0]           ch_mask,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic                               eng_clr,
  output logic [CH_W-1:0]                    eng_ch,
  input  logic                               eng_finished,
  input  logic [DATAWIDTH-1:0]               eng_avg,
  input  logic [DATAWIDTH-1:0]               eng_sum,
  output logic [DATAWIDTH*CHANNEL_COUNT-1:0] avg_out,
  output logic [DATAWIDTH*CHANNEL_COUNT-1:0] sum_out,
  output logic [CHANNEL_COUNT-1:0]           valid_out
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_NEXT, S_DONE} state_t;

  state_t                            state_q, state_d;
  logic [CHANNEL_COUNT-1:0]          pending_q, pending_d, remaining;
  logic [15:0]                       timer_q, timer_d;
  logic [CH_W-1:0]                   eng_ch_q, eng_ch_d;
  logic [DATAWIDTH*CHANNEL_COUNT-1:0] avg_q, avg_d, sum_q, sum_d;
  logic [CHANNEL_COUNT-1:0]          valid_q, valid_d;
  logic                              error_q, error_d;
  logic                              busy_q, busy_d, done_q, done_d, eng_clr_q, eng_clr_d;

  function automatic logic [CH_W-1:0] lowest_set(input logic [CHANNEL_COUNT-1:0] m);
    logic [CH_W-1:0] r;
    r = '0;
    for (int unsigned i = CHANNEL_COUNT; i > 0; i--) begin
      if (m[i-1]) r = CH_W'(i-1);
    end
    return r;
  endfunction

  always_comb begin
    remaining = pending_q;
    for (int unsigned c = 0; c < CHANNEL_COUNT; c++) begin
      if (eng_ch_q == CH_W'(c)) remaining[c] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      timer_q   <= '0;
      eng_ch_q  <= '0;
      avg_q     <= '0;
      sum_q     <= '0;
      valid_q   <= '0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      eng_clr_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      timer_q   <= timer_d;
      eng_ch_q  <= eng_ch_d;
      avg_q     <= avg_d;
      sum_q     <= sum_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      eng_clr_q <= eng_clr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    timer_d   = timer_q;
    eng_ch_d  = eng_ch_q;
    avg_d     = avg_q;
    sum_d     = sum_q;
    valid_d   = valid_q;
    error_d   = error_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pending_d = ch_mask;
          valid_d   = '0;
          error_d   = 1'b0;
          if (ch_mask == '0) begin
            state_d = S_DONE;
          end else begin
            eng_ch_d = lowest_set(ch_mask);
            state_d  = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        timer_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        // A result arriving on the watchdog's last cycle still counts as a capture.
        if (eng_finished) begin
          for (int unsigned c = 0; c < CHANNEL_COUNT; c++) begin
            if (eng_ch_q == CH_W'(c)) begin
              avg_d[c*DATAWIDTH +: DATAWIDTH] = eng_avg;
              sum_d[c*DATAWIDTH +: DATAWIDTH] = eng_sum;
              valid_d[c]                      = 1'b1;
            end
          end
          state_d = S_NEXT;
        end else if (timer_q == TIMEOUT) begin
          error_d = 1'b1;
          state_d = S_NEXT;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_NEXT: begin
        pending_d = remaining;
        if (remaining != '0) begin
          eng_ch_d = lowest_set(remaining);
          state_d  = S_CLEAR;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    busy_d    = (state_d == S_CLEAR) || (state_d == S_RUN) || (state_d == S_NEXT);
    done_d    = (state_d == S_DONE);
    eng_clr_d = (state_d != S_RUN);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign eng_clr   = eng_clr_q;
  assign eng_ch    = eng_ch_q;
  assign avg_out   = avg_q;
  assign sum_out   = sum_q;
  assign valid_out = valid_q;

endmodule

// File: doc/avg_pool_channel_sched.md
# avg_pool_channel_sched

Time-multiplexing scheduler that lets one shared single-channel average-pooling engine serve CHANNEL_COUNT channels. It sits between the layer controller and the pooling engine: it accepts a start command with a channel mask, steps the engine through each selected channel, captures each channel's average and sum into per-channel result registers, and reports completion. The upstream window multiplexer uses `eng_ch` to route the selected channel's matrix to the engine.

## Interface

- DATAWIDTH, 32, width of engine avg/sum results (FP32 bit patterns, passed through untouched)
- CHANNEL_COUNT, 4, number of channels scheduled (≥1)
- TIMEOUT, 16'd1023, RUN-state watchdog limit in cycles (16-bit)
- CH_W, $clog2(CHANNEL_COUNT) (min 1), width of `eng_ch`

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request a pass; sampled only in IDLE
- ch_mask  in  CHANNEL_COUNT  channels to process this pass; latched with start
- busy  out  1  high in CLEAR, RUN, NEXT
- done  out  1  one-cycle pulse at end of pass
- error  out  1  sticky: a channel timed out this pass
- eng_clr  out  1  holds engine cleared; low only in RUN
- eng_ch  out  CH_W  channel currently routed to engine
- eng_finished  in  1  engine result-ready level
- eng_avg  in  DATAWIDTH  engine average
- eng_sum  in  DATAWIDTH  engine sum
- avg_out  out  DATAWIDTH × CHANNEL_COUNT  captured averages
- sum_out  out  DATAWIDTH × CHANNEL_COUNT  captured sums
- valid_out  out  CHANNEL_COUNT  per-channel result captured this pass

## Operation

- States: IDLE, CLEAR, RUN, NEXT, DONE. All outputs registered.
- IDLE: eng_clr=1. On start=1: latch pending=ch_mask, clear valid_out and error; if pending==0 go DONE, else eng_ch=lowest set bit of pending and go CLEAR. start=0: stay.
- CLEAR (1 cycle): eng_clr=1, eng_ch stable → RUN, timer=0.
- RUN: eng_clr=0. eng_finished=1: avg_out[eng_ch]=eng_avg, sum_out[eng_ch]=eng_sum, valid_out[eng_ch]=1 → NEXT. Else if timer==TIMEOUT: error=1, valid_out[eng_ch] stays 0 → NEXT. Else timer+1.
- NEXT (1 cycle): eng_clr=1, clear pending[eng_ch]; remaining pending≠0 → eng_ch=lowest remaining bit, CLEAR; else DONE.
- DONE (1 cycle): done=1 → IDLE.
- Channels processed in ascending index order; unmasked channels are never selected and keep prior avg_out/sum_out with valid_out=0.
- eng_finished ignored outside RUN. Finished and timeout in the same cycle: finished wins (capture, no error).
- start outside IDLE (including DONE cycle) ignored; ch_mask sampled only with accepted start.
- avg_out/sum_out are not cleared at start; only overwritten on capture.

## Timing

- Reset (async assert, any state): state=IDLE, busy=0, done=0, error=0, eng_clr=1, eng_ch=0, pending=0, timer=0, avg_out=sum_out=0, valid_out=0. Mid-pass reset aborts immediately; no done pulse.
- Start accepted at cycle T0 (IDLE). Engine latency L = RUN cycles before eng_finished seen (finished in first RUN cycle → L=0).
- Per channel: CLEAR 1 + RUN L+1 + NEXT 1 = L+3 cycles. N channels: done high at T0+1+Σ(Lᵢ+3).
- Empty mask: done at T0+1, busy never asserted, eng_clr stays 1.
- Timed-out channel occupies TIMEOUT+1 RUN cycles.
- valid_out[c], avg_out[c], sum_out[c] update on the edge ending the capturing RUN cycle, visible in the NEXT cycle; stable through done and IDLE.
- New start possible in the cycle after done (first IDLE cycle).

## Test plan

- CHANNEL_COUNT=4, mask=4'b1111, engine model finishes at L=2 with avg=32'h3F800000+c, sum=32'h41000000+c → eng_ch sequence 0,1,2,3; done at T0+21; valid_out=4'b1111; values match per channel; error=0.
- mask=4'b1010, L=0 → only channels 1,3 selected; done at T0+7; valid_out=4'b1010; channels 0,2 keep previous values.
- mask=0 → done at T0+1, busy=0 throughout, eng_clr=1 throughout, valid_out=0.
- TIMEOUT=5, mask=4'b0011, channel 0 engine never finishes, channel 1 L=1 → channel 0 leaves RUN after 6 cycles, error=1, valid_out=4'b0010, done at T0+1+(5+3)+(1+3)=T0+13.
- Pulse start during busy and during DONE → ignored, no second pass; finished asserted during CLEAR ignored; finished on timeout cycle → captured, error=0.
- Drop rst mid-RUN on channel 2 → same-cycle async clear: busy=0, eng_clr=1, valid_out=0, no done; fresh start after release runs normally.
